// File: rtl/tone_mixer_pwm.sv
// Test-tone output stage: sample-rate step strobe, delayed capture of the two
// sine generator outputs, saturating mix with volume/mute, and a 256-cycle PWM.
module tone_mixer_pwm #(
  parameter int CYCLES_PER_SAMPLE = 8192,
  parameter int LUT_LATENCY       = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       enable_in,
  input  logic       mute_in,
  input  logic [1:0] volume_in,
  input  logic [7:0] tone_a_in,
  input  logic [7:0] tone_b_in,
  output logic       step_out,
  output logic [7:0] sample_out,
  output logic       sample_valid_out,
  output logic       pwm_out
);

  localparam logic [15:0] SAMP_LAST = 16'(CYCLES_PER_SAMPLE - 1);
  localparam logic [15:0] SAMP_PRE  = 16'(CYCLES_PER_SAMPLE - 2);
  localparam logic [3:0]  WAIT_LOAD = 4'(LUT_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        samp_cnt_q, samp_cnt_d;
  logic               step_q, step_d;
  logic [3:0]         wait_q, wait_d;
  logic [7:0]         sample_q, sample_d;
  logic               valid_q, valid_d;
  logic [7:0]         pwm_cnt_q;
  logic [7:0]         duty_q, duty_d;
  logic               pwm_q;

  logic signed [8:0]  sum_s;
  logic signed [7:0]  clip_s;
  logic signed [7:0]  mix_s;

  // Sample counter and strobe; the strobe is registered one count early so it
  // lines up with samp_cnt == CYCLES_PER_SAMPLE-1.
  always_comb begin
    samp_cnt_d = 16'd0;
    step_d     = 1'b0;
    if (enable_in) begin
      if (samp_cnt_q == SAMP_LAST) begin
        samp_cnt_d = 16'd0;
      end else begin
        samp_cnt_d = samp_cnt_q + 16'd1;
      end
      step_d = (samp_cnt_q == SAMP_PRE);
    end else begin
      samp_cnt_d = 16'd0;
      step_d     = 1'b0;
    end
  end

  // Saturating mix followed by sign-preserving volume shift.
  always_comb begin
    sum_s = $signed({tone_a_in[7], tone_a_in}) + $signed({tone_b_in[7], tone_b_in});
    if (sum_s > 9'sd127) begin
      clip_s = 8'sd127;
    end else if (sum_s < -9'sd128) begin
      clip_s = -8'sd128;
    end else begin
      clip_s = sum_s[7:0];
    end
    if (mute_in) begin
      mix_s = 8'sd0;
    end else begin
      mix_s = clip_s >>> volume_in;
    end
  end

  // Capture FSM: exits WAIT as the counter would reach zero, so tones are
  // sampled exactly LUT_LATENCY edges after the strobe.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    if (!enable_in) begin
      state_d = S_IDLE;
      wait_d  = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (step_q) begin
            wait_d  = WAIT_LOAD;
            state_d = (WAIT_LOAD == 4'd0) ? S_CAPTURE : S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          if (wait_q <= 4'd1) begin
            wait_d  = 4'd0;
            state_d = S_CAPTURE;
          end else begin
            wait_d  = wait_q - 4'd1;
            state_d = S_WAIT;
          end
        end
        S_CAPTURE: begin
          sample_d = mix_s;
          valid_d  = 1'b1;
          state_d  = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          wait_d  = 4'd0;
        end
      endcase
    end
  end

  // Duty reloads only at the period boundary to keep each PWM period clean.
  always_comb begin
    if (pwm_cnt_q == 8'hFF) begin
      duty_d = {~sample_q[7], sample_q[6:0]};
    end else begin
      duty_d = duty_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      samp_cnt_q <= 16'd0;
      step_q     <= 1'b0;
      wait_q     <= 4'd0;
      sample_q   <= 8'd0;
      valid_q    <= 1'b0;
      pwm_cnt_q  <= 8'd0;
      duty_q     <= 8'd128;
      pwm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      step_q     <= step_d;
      wait_q     <= wait_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      pwm_cnt_q  <= pwm_cnt_q + 8'd1;
      duty_q     <= duty_d;
      pwm_q      <= (pwm_cnt_q < duty_q);
    end
  end

  assign step_out         = step_q;
  assign sample_out       = sample_q;
  assign sample_valid_out = valid_q;
  assign pwm_out          = pwm_q;

endmodule

// File: doc/tone_mixer_pwm.md
# tone_mixer_pwm

Sample-rate sequencer and audio output stage for the test-tone path. Generates the one-cycle phase-step strobe that advances both sine generators. Captures their signed 8-bit outputs once the registered sine lookup has settled, then mixes them with saturation and volume scaling. Drives a 1-bit PWM audio pin from the result and also presents the mixed sample to the transcription front end.

## Interface
Parameters:
- CYCLES_PER_SAMPLE, 8192: clock cycles per audio sample (98.304 MHz / 12 kHz); legal range 256..65535.
- LUT_LATENCY, 2: cycles from step_out high to valid tone inputs (1 phase register + 1 LUT register); legal range 1..8.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset (0 = reset)
- enable_in  input  1  run sequencer; 0 halts stepping and capture
- mute_in  input  1  force mixed sample to 0
- volume_in  input  2  arithmetic right shift applied after mixing (0..3)
- tone_a_in  input  8  signed tone sample A (2's complement)
- tone_b_in  input  8  signed tone sample B (2's complement)
- step_out  output  1  one-cycle phase-step strobe to the sine generators
- sample_out  output  8  signed mixed sample
- sample_valid_out  output  1  one-cycle pulse, sample_out updated this cycle
- pwm_out  output  1  PWM audio bit

## Operation
- Sample counter samp_cnt (16 b):
  - While enable_in=1: counts 0..CYCLES_PER_SAMPLE-1 and wraps.
  - step_out=1 exactly in the cycle samp_cnt==CYCLES_PER_SAMPLE-1.
  - While enable_in=0: samp_cnt is held at 0 and step_out=0.
- Capture FSM, states IDLE, WAIT, CAPTURE:
  - IDLE -> WAIT on step_out=1; the wait counter loads LUT_LATENCY-1.
  - WAIT decrements each cycle; at 0 -> CAPTURE.
  - CAPTURE samples the tone inputs, registers the result, and returns to IDLE.
  - Any state -> IDLE in the cycle enable_in=0. No sample_valid_out is produced for an aborted capture.
- Mix arithmetic, in CAPTURE:
  - sum = sign-extended tone_a_in + tone_b_in (9 b signed).
  - Clip sum to [-128, 127].
  - Apply volume_in as an arithmetic right shift (>>>), so the sign is preserved.
  - mute_in=1 at capture forces the result to 0.
- Output register:
  - sample_out <= result; sample_valid_out=1 for the following cycle only.
  - sample_out holds its value between captures.
- PWM:
  - pwm_cnt (8 b) is free-running whenever reset is deasserted, independent of enable_in.
  - duty (8 b) reloads only in the cycle pwm_cnt==255, from {~sample_out[7], sample_out[6:0]} (offset binary). This keeps updates glitch-free mid-period.
  - pwm_out is registered as (pwm_cnt < duty). duty=0 gives constant 0; duty=255 gives high for 255 of 256 cycles.

## Timing
- Reset (rst_in=0, asynchronous):
  - samp_cnt=0, pwm_cnt=0, state IDLE.
  - step_out=0, sample_out=0, sample_valid_out=0, pwm_out=0, duty=128.
  - Release is taken synchronously; the first step_out occurs CYCLES_PER_SAMPLE cycles after the first enabled edge.
- Step period is exactly CYCLES_PER_SAMPLE cycles; step_out is never wider than 1 cycle.
- With step_out high in cycle t:
  - Tone inputs are sampled at the edge ending cycle t+LUT_LATENCY.
  - sample_valid_out is high in cycle t+LUT_LATENCY+1.
- A new step cannot arrive during WAIT, since CYCLES_PER_SAMPLE ≥ 256 > LUT_LATENCY.
- pwm_out is 1 cycle behind the comparison. Its period is 256 cycles, giving 384 kHz at 98.304 MHz.
- mute_in and volume_in are sampled only in CAPTURE; changes between captures have no effect until the next sample.
- Reset asserted mid-WAIT or mid-PWM-period returns every output to its reset value immediately.

## Test plan
- Reset/idle: rst_in=0 then released, enable_in=0 for 10000 cycles -> step_out, sample_valid_out stay 0; pwm_out is high for 128 of every 256 cycles.
- Step cadence: enable_in=1, CYCLES_PER_SAMPLE=256 -> step_out pulses every 256 cycles, first pulse 256 cycles after enable; sample_valid_out follows each step by 3 cycles.
- Saturation and volume:
  - a=100, b=100, volume 0 -> sample_out=127.
  - a=-100, b=-100 -> -128.
  - a=-100, b=-100, volume 2 -> -32.
  - a=50, b=-20, volume 1 -> 15.
- Mute/PWM extremes:
  - mute_in=1 -> sample_out=0, duty=128.
  - a=b=-128 -> duty=0, pwm_out constant 0.
  - a=b=127 -> duty=255, pwm_out low exactly 1 of 256 cycles.
- Abort: drop enable_in in the cycle after step_out -> no sample_valid_out; sample_out unchanged; re-enable restarts the count from 0.
- Async reset mid-operation: assert rst_in between clock edges during WAIT -> all outputs 0 before the next edge; PWM restarts at duty 128.
